// File: rtl/bp_me_cache_dma_to_cce_pkg.sv
// Shared types and sizes for the bsg_cache DMA to CCE memory bridge:
// the CCE memory message, the cache DMA packet and block geometry.
package bp_me_cache_dma_to_cce_pkg;

    localparam int paddr_width_p     = 40;
    localparam int cce_block_width_p = 512;
    localparam int dword_width_p     = 64;
    localparam int mem_payload_width_lp = 16;

    localparam int block_size_in_words_lp = cce_block_width_p / dword_width_p;
    localparam int block_offset_width_lp  = $clog2(cce_block_width_p / 8);
    localparam int word_cnt_width_lp      = $clog2(block_size_in_words_lp);

    localparam logic [word_cnt_width_lp-1:0] last_word_lp =
        word_cnt_width_lp'(block_size_in_words_lp - 1);

    typedef enum logic [3:0] {
        e_mem_msg_rd    = 4'b0000,
        e_mem_msg_wr    = 4'b0001,
        e_mem_msg_uc_rd = 4'b0010,
        e_mem_msg_uc_wr = 4'b0011
    } bp_mem_msg_e;

    typedef enum logic [2:0] {
        e_mem_msg_size_1  = 3'b000,
        e_mem_msg_size_2  = 3'b001,
        e_mem_msg_size_4  = 3'b010,
        e_mem_msg_size_8  = 3'b011,
        e_mem_msg_size_16 = 3'b100,
        e_mem_msg_size_32 = 3'b101,
        e_mem_msg_size_64 = 3'b110
    } bp_mem_msg_size_e;

    typedef struct packed {
        logic [mem_payload_width_lp-1:0] payload;
        bp_mem_msg_size_e                size;
        logic [paddr_width_p-1:0]        addr;
        bp_mem_msg_e                     msg_type;
    } bp_cce_mem_msg_header_s;

    typedef struct packed {
        logic [cce_block_width_p-1:0] data;
        bp_cce_mem_msg_header_s       header;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

    typedef struct packed {
        logic                     write_not_read;
        logic [paddr_width_p-1:0] addr;
    } bsg_cache_dma_pkt_s;

    localparam int dma_pkt_width_lp = $bits(bsg_cache_dma_pkt_s);

    // Clear the byte offset so the command always names a whole block.
    function automatic logic [paddr_width_p-1:0] block_align(input logic [paddr_width_p-1:0] addr);
        logic [paddr_width_p-1:0] aligned;
        aligned = addr;
        aligned[block_offset_width_lp-1:0] = '0;
        return aligned;
    endfunction

endpackage

// File: rtl/bp_me_cache_dma_to_cce_counter.sv
// Word index counter with synchronous clear and increment.
module bp_me_cache_dma_to_cce_counter #(
    parameter int width_p = 3
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q, count_d;

    // Clear takes priority over increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (up_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bp_me_cache_dma_to_cce.sv
// Bridge from the bsg_cache DMA port to one full-block CCE memory command
// per packet. One transaction is in flight at a time; a single block
// register collects write data and later holds the read response.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high (yumi outputs are ready driven from the matching valid); valid
// sources hold their payload stable until the transfer.
module bp_me_cache_dma_to_cce
    import bp_me_cache_dma_to_cce_pkg::*;
(
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [dma_pkt_width_lp-1:0]     dma_pkt_i,
    input  logic                            dma_pkt_v_i,
    output logic                            dma_pkt_yumi_o,
    input  logic [dword_width_p-1:0]        dma_data_i,
    input  logic                            dma_data_v_i,
    output logic                            dma_data_ready_o,
    output logic [dword_width_p-1:0]        dma_data_o,
    output logic                            dma_data_v_o,
    input  logic                            dma_data_yumi_i,
    output logic [cce_mem_msg_width_lp-1:0] mem_cmd_o,
    output logic                            mem_cmd_v_o,
    input  logic                            mem_cmd_ready_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_resp_i,
    input  logic                            mem_resp_v_i,
    output logic                            mem_resp_yumi_o
);

    typedef enum logic [2:0] {
        e_ready,
        e_wr_data,
        e_send_cmd,
        e_wait_resp,
        e_rd_data
    } state_e;

    state_e                                                     state_q, state_d;
    logic [block_size_in_words_lp-1:0][dword_width_p-1:0]       block_q, block_d;
    logic [paddr_width_p-1:0]                                   addr_q, addr_d;
    logic                                                       wr_q, wr_d;
    // Low in the reset cycle and the one after it; gates every handshake.
    logic                                                       live_q, live_d;
    logic                                                       live;

    logic [word_cnt_width_lp-1:0] cnt;
    logic                         cnt_up, cnt_clear;

    bsg_cache_dma_pkt_s dma_pkt;
    bp_cce_mem_msg_s    mem_resp;
    bp_cce_mem_msg_s    mem_cmd;

    logic pkt_yumi, data_ready, data_v, cmd_v, resp_yumi;

    assign dma_pkt  = dma_pkt_i;
    assign mem_resp = mem_resp_i;
    assign live     = live_q & ~reset_i;

    bp_me_cache_dma_to_cce_counter #(
        .width_p (word_cnt_width_lp)
    ) word_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (cnt_clear),
        .up_i    (cnt_up),
        .count_o (cnt)
    );

    // Next-state, handshake and block register update for the transaction FSM.
    always_comb begin
        state_d    = state_q;
        block_d    = block_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        live_d     = 1'b1;
        cnt_up     = 1'b0;
        cnt_clear  = 1'b0;
        pkt_yumi   = 1'b0;
        data_ready = 1'b0;
        data_v     = 1'b0;
        cmd_v      = 1'b0;
        resp_yumi  = 1'b0;
        case (state_q)
            e_ready: begin
                pkt_yumi = live & dma_pkt_v_i;
                if (pkt_yumi) begin
                    addr_d  = block_align(dma_pkt.addr);
                    wr_d    = dma_pkt.write_not_read;
                    state_d = dma_pkt.write_not_read ? e_wr_data : e_send_cmd;
                end
            end
            e_wr_data: begin
                data_ready = live;
                if (live && dma_data_v_i) begin
                    block_d[cnt] = dma_data_i;
                    if (cnt == last_word_lp) begin
                        cnt_clear = 1'b1;
                        state_d   = e_send_cmd;
                    end else begin
                        cnt_up = 1'b1;
                    end
                end
            end
            e_send_cmd: begin
                cmd_v = live;
                if (live && mem_cmd_ready_i) begin
                    state_d = e_wait_resp;
                end
            end
            e_wait_resp: begin
                resp_yumi = live & mem_resp_v_i;
                if (resp_yumi) begin
                    if (wr_q) begin
                        state_d = e_ready;
                    end else begin
                        block_d = mem_resp.data;
                        state_d = e_rd_data;
                    end
                end
            end
            e_rd_data: begin
                data_v = live;
                if (live && dma_data_yumi_i) begin
                    if (cnt == last_word_lp) begin
                        cnt_clear = 1'b1;
                        state_d   = e_ready;
                    end else begin
                        cnt_up = 1'b1;
                    end
                end
            end
            default: state_d = e_ready;
        endcase
    end

    // FSM and datapath registers; reset drops any half-built transaction.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_ready;
            block_q <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            block_q <= block_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            live_q  <= live_d;
        end
    end

    // Command is built purely from registered state so it holds while stalled.
    always_comb begin
        mem_cmd                 = '0;
        mem_cmd.header.msg_type = wr_q ? e_mem_msg_wr : e_mem_msg_rd;
        mem_cmd.header.addr     = addr_q;
        mem_cmd.header.size     = e_mem_msg_size_64;
        mem_cmd.header.payload  = '0;
        mem_cmd.data            = wr_q ? block_q : '0;
    end

    assign dma_pkt_yumi_o   = pkt_yumi;
    assign dma_data_ready_o = data_ready;
    assign dma_data_v_o     = data_v;
    assign dma_data_o       = block_q[cnt];
    assign mem_cmd_o        = mem_cmd;
    assign mem_cmd_v_o      = cmd_v;
    assign mem_resp_yumi_o  = resp_yumi;

    // Response header fields other than the type are not needed here.
    logic unused_resp_hdr;
    assign unused_resp_hdr = ^{mem_resp.header.addr, mem_resp.header.size,
                               mem_resp.header.payload, mem_resp.header.msg_type};

    // A response must be of the same kind as the command that produced it.
    resp_type_match: assert property (@(posedge clk_i) disable iff (reset_i)
        (state_q == e_wait_resp && mem_resp_v_i) |-> (mem_resp.header.msg_type == mem_cmd.header.msg_type));

endmodule

// File: tb/tb_bp_me_cache_dma_to_cce.sv
// Directed and randomized bench for the DMA to CCE bridge with a block-level
// reference model and an expected-word queue for read data.
module tb_bp_me_cache_dma_to_cce;
    import bp_me_cache_dma_to_cce_pkg::*;

    localparam int msg_w = cce_mem_msg_width_lp;
    localparam int pkt_w = dma_pkt_width_lp;
    localparam int dw    = dword_width_p;
    localparam int nw    = block_size_in_words_lp;
    localparam int bw    = cce_block_width_p;

    logic              clk_i, reset_i;
    logic [pkt_w-1:0]  dma_pkt_i;
    logic              dma_pkt_v_i, dma_pkt_yumi_o;
    logic [dw-1:0]     dma_data_i;
    logic              dma_data_v_i, dma_data_ready_o;
    logic [dw-1:0]     dma_data_o;
    logic              dma_data_v_o, dma_data_yumi_i;
    logic [msg_w-1:0]  mem_cmd_o;
    logic              mem_cmd_v_o, mem_cmd_ready_i;
    logic [msg_w-1:0]  mem_resp_i;
    logic              mem_resp_v_i, mem_resp_yumi_o;

    bp_me_cache_dma_to_cce dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .dma_pkt_i        (dma_pkt_i),
        .dma_pkt_v_i      (dma_pkt_v_i),
        .dma_pkt_yumi_o   (dma_pkt_yumi_o),
        .dma_data_i       (dma_data_i),
        .dma_data_v_i     (dma_data_v_i),
        .dma_data_ready_o (dma_data_ready_o),
        .dma_data_o       (dma_data_o),
        .dma_data_v_o     (dma_data_v_o),
        .dma_data_yumi_i  (dma_data_yumi_i),
        .mem_cmd_o        (mem_cmd_o),
        .mem_cmd_v_o      (mem_cmd_v_o),
        .mem_cmd_ready_i  (mem_cmd_ready_i),
        .mem_resp_i       (mem_resp_i),
        .mem_resp_v_i     (mem_resp_v_i),
        .mem_resp_yumi_o  (mem_resp_yumi_o)
    );

    // Clock and cycle index.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Handshake monitors.
    int n_pkt_hs = 0, n_cmd_hs = 0, n_rd_hs = 0;
    always @(negedge clk_i) begin
        if (!reset_i && dma_pkt_yumi_o) n_pkt_hs++;
        if (!reset_i && mem_cmd_v_o && mem_cmd_ready_i) n_cmd_hs++;
        if (!reset_i && dma_data_v_o && dma_data_yumi_i) n_rd_hs++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard state.
    int n_total = 0, n_pass = 0;
    int exp_pkts = 0, exp_cmds = 0, exp_beats = 0;
    int acc_cyc, start_cyc, done_cyc;
    logic [dw-1:0] exp_q[$];
    bit nxt_v = 0;
    logic [pkt_w-1:0] nxt_pkt = '0;

    task automatic check(input string tag, input logic [msg_w-1:0] obs, input logic [msg_w-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [4:0] hs_outs();
        return {dma_pkt_yumi_o, dma_data_ready_o, dma_data_v_o, mem_cmd_v_o, mem_resp_yumi_o};
    endfunction

    // Reference: the command a packet should produce.
    function automatic bp_cce_mem_msg_s model_cmd(input logic wr, input logic [paddr_width_p-1:0] a,
                                                  input logic [bw-1:0] d);
        bp_cce_mem_msg_s m;
        m = '0;
        m.header.msg_type = wr ? e_mem_msg_wr : e_mem_msg_rd;
        m.header.addr     = a - (a % 64);
        m.header.size     = e_mem_msg_size_64;
        m.header.payload  = '0;
        m.data            = wr ? d : '0;
        return m;
    endfunction

    function automatic logic [bw-1:0] rand_block();
        logic [bw-1:0] b;
        for (int i = 0; i < nw; i++) b[i*dw +: dw] = {$urandom, $urandom};
        return b;
    endfunction

    function automatic logic [paddr_width_p-1:0] rand_addr();
        return {8'h00, $urandom};
    endfunction

    // Driver: offer a packet (or use one already preloaded) until taken.
    task automatic accept_pkt(input logic wnr, input logic [paddr_width_p-1:0] a, input bit b2b);
        if (!b2b) begin
            dma_pkt_i   = {wnr, a};
            dma_pkt_v_i = 1'b1;
        end
        settle();
        for (int i = 0; i < 60 && !dma_pkt_yumi_o; i++) begin tick(); settle(); end
        check("pkt_yumi", dma_pkt_yumi_o, 1);
        if (b2b) check("b2b_accept_cycle", cyc, done_cyc + 1);
        acc_cyc   = cyc;
        start_cyc = cyc;
        exp_pkts++;
        tick();
        dma_pkt_v_i = nxt_v;
        dma_pkt_i   = nxt_pkt;
        nxt_v       = 0;
    endtask

    task automatic handle_cmd(input bp_cce_mem_msg_s e, input int stall);
        mem_cmd_ready_i = 1'b0;
        settle();
        for (int i = 0; i < 60 && !mem_cmd_v_o; i++) begin tick(); settle(); end
        check("cmd_v", mem_cmd_v_o, 1);
        check("cmd_latency", cyc, start_cyc + 1);
        for (int i = 0; i < stall; i++) begin
            check("cmd_hold", mem_cmd_o, e);
            tick();
            settle();
        end
        mem_cmd_ready_i = 1'b1;
        settle();
        check("cmd", mem_cmd_o, e);
        exp_cmds++;
        tick();
        mem_cmd_ready_i = 1'b0;
    endtask

    task automatic handle_resp(input logic wr, input logic [paddr_width_p-1:0] a,
                               input logic [bw-1:0] d, input int delay);
        bp_cce_mem_msg_s r;
        repeat (delay) tick();
        r = '0;
        r.header.msg_type = wr ? e_mem_msg_wr : e_mem_msg_rd;
        r.header.addr     = a;
        r.header.size     = e_mem_msg_size_64;
        r.data            = wr ? '0 : d;
        mem_resp_i   = r;
        mem_resp_v_i = 1'b1;
        settle();
        for (int i = 0; i < 60 && !mem_resp_yumi_o; i++) begin tick(); settle(); end
        check("resp_yumi", mem_resp_yumi_o, 1);
        done_cyc  = cyc;
        start_cyc = cyc;
        tick();
        mem_resp_v_i = 1'b0;
    endtask

    // Drain expected read words from the queue, yumi-ing at the given rate.
    task automatic read_out(input int yumi_pct);
        bit first = 1;
        for (int g = 0; g < 400 && exp_q.size() > 0; g++) begin
            settle();
            if (dma_data_v_o) begin
                if (first) begin
                    check("rd_latency", cyc, start_cyc + 1);
                    first = 0;
                end
                check("rd_word", dma_data_o, exp_q[0]);
                if ($urandom_range(99, 0) < yumi_pct) begin
                    dma_data_yumi_i = 1'b1;
                    void'(exp_q.pop_front());
                    exp_beats++;
                    done_cyc = cyc;
                end
            end
            tick();
            dma_data_yumi_i = 1'b0;
        end
        check("rd_all_words", exp_q.size(), 0);
        if (yumi_pct >= 100) check("rd_burst_len", done_cyc, start_cyc + nw);
    endtask

    task automatic do_read(input logic [paddr_width_p-1:0] a, input logic [bw-1:0] blk,
                           input int stall, input int delay, input int yumi_pct, input bit b2b);
        accept_pkt(1'b0, a, b2b);
        handle_cmd(model_cmd(1'b0, a, '0), stall);
        for (int i = 0; i < nw; i++) exp_q.push_back(blk[i*dw +: dw]);
        handle_resp(1'b0, a, blk, delay);
        read_out(yumi_pct);
    endtask

    task automatic do_write(input logic [paddr_width_p-1:0] a, input logic [bw-1:0] blk,
                            input int stall, input int gap, input int delay, input bit b2b);
        accept_pkt(1'b1, a, b2b);
        for (int i = 0; i < nw; i++) begin
            repeat ($urandom_range(gap, 0)) begin
                dma_data_v_i = 1'b0;
                dma_data_i   = {$urandom, $urandom};
                tick();
            end
            dma_data_v_i = 1'b1;
            dma_data_i   = blk[i*dw +: dw];
            settle();
            for (int j = 0; j < 60 && !dma_data_ready_o; j++) begin tick(); settle(); end
            check("wr_ready", dma_data_ready_o, 1);
            start_cyc = cyc;
            tick();
            dma_data_v_i = 1'b0;
        end
        handle_cmd(model_cmd(1'b1, a, blk), stall);
        handle_resp(1'b1, a, '0, delay);
        settle();
        check("no_rd_data_after_wr", dma_data_v_o, 0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pkts"}, n_pkt_hs, exp_pkts);
        check({tag, "_cmds"}, n_cmd_hs, exp_cmds);
        check({tag, "_beats"}, n_rd_hs, exp_beats);
    endtask

    logic [bw-1:0] blk;
    logic [paddr_width_p-1:0] ra;

    initial begin
        dma_pkt_i = '0; dma_data_i = '0; mem_resp_i = '0;
        dma_data_yumi_i = 0; mem_cmd_ready_i = 0;
        // Reset with every input valid asserted: nothing may handshake.
        reset_i = 1; dma_pkt_v_i = 1; dma_data_v_i = 1; mem_resp_v_i = 1;
        tick();
        settle();
        check("reset_outs", hs_outs(), 0);
        reset_i = 0;
        settle();
        check("post_reset_outs", hs_outs(), 0);
        dma_pkt_v_i = 0; dma_data_v_i = 0; mem_resp_v_i = 0;
        tick();

        // Directed read: words 0x11..0x88.
        for (int i = 0; i < nw; i++) blk[i*dw +: dw] = 64'(8'h11 * (i + 1));
        do_read(40'h00_8000_1234, blk, 0, 1, 100, 0);

        // Directed write: words 0xA0..0xA7 with gaps.
        for (int i = 0; i < nw; i++) blk[i*dw +: dw] = 64'(8'hA0 + i);
        do_write(40'h00_8000_0040, blk, 0, 2, 1, 0);
        check_counts("directed");

        // Backpressure.
        do_read(rand_addr(), rand_block(), 5, 2, 50, 0);
        do_write(rand_addr(), rand_block(), 5, 1, 0, 0);

        // Back-to-back read, write, read with packet valid held high.
        begin
            int cmds0;
            cmds0 = n_cmd_hs;
            ra = rand_addr();
            nxt_v = 1; nxt_pkt = {1'b1, ra};
            do_read(rand_addr(), rand_block(), 1, 0, 100, 0);
            nxt_v = 1; nxt_pkt = {1'b0, rand_addr()};
            do_write(ra, rand_block(), 0, 0, 0, 1);
            do_read(nxt_pkt[paddr_width_p-1:0], rand_block(), 0, 0, 100, 1);
            check("b2b_cmd_count", n_cmd_hs - cmds0, 3);
        end
        check_counts("b2b");

        // Spurious data and response while idle are ignored.
        dma_data_v_i = 1; mem_resp_v_i = 1; mem_resp_i = model_cmd(1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("idle_data_ready", dma_data_ready_o, 0);
            check("idle_resp_yumi", mem_resp_yumi_o, 0);
            tick();
        end
        dma_data_v_i = 0; mem_resp_v_i = 0;
        do_read(rand_addr(), rand_block(), 0, 0, 100, 0);

        // Reset after 3 of 8 write words.
        accept_pkt(1'b1, rand_addr(), 0);
        for (int i = 0; i < 3; i++) begin
            dma_data_v_i = 1; dma_data_i = {$urandom, $urandom};
            settle();
            check("abort_wr_ready", dma_data_ready_o, 1);
            tick();
        end
        reset_i = 1; dma_pkt_v_i = 1; dma_data_v_i = 1; mem_resp_v_i = 1;
        settle();
        check("mid_reset_outs", hs_outs(), 0);
        tick();
        reset_i = 0;
        settle();
        check("mid_post_reset_outs", hs_outs(), 0);
        dma_pkt_v_i = 0; dma_data_v_i = 0; mem_resp_v_i = 0;
        tick();
        do_read(rand_addr(), rand_block(), 2, 1, 100, 0);
        check_counts("after_abort");

        // Randomized transactions.
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(1, 0) == 1)
                do_write(rand_addr(), rand_block(), $urandom_range(3, 0), $urandom_range(2, 0),
                         $urandom_range(3, 0), 0);
            else
                do_read(rand_addr(), rand_block(), $urandom_range(3, 0), $urandom_range(3, 0),
                        $urandom_range(100, 30), 0);
        end
        check_counts("final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
